// File: rtl/regfile_io.sv
// regfile_io: processor register file with a window of hardware-loadable I/O
// registers.
//   clock / ctrl_reset        : rising-edge clock, async active-low reset
//   ctrl_writeEnable/...Reg   : single CPU write port (data_writeReg)
//   ctrl_readRegA/B           : two combinational read ports (data_readRegA/B)
//   io_load / io_data         : per-I/O-register hardware load strobe + data
//   io_pending / io_overrun   : per-I/O-register event flags
//   reg_taps                  : every register's stored value, slice i = reg i
// Register 0 is hardwired to zero. A CPU write to an I/O register acknowledges
// it (clears its flags) unless a hardware load lands on the same edge.

// One I/O register: data plus pending/overrun flags.
module regfile_io_ioreg #(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [DW-1:0] ldata_i,
  input  logic          wr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] q_o,
  output logic [DW-1:0] nxt_o,
  output logic          upd_o,
  output logic          pend_o,
  output logic          ovr_o
);
  logic [DW-1:0] q_q;
  logic          pend_q, pend_d;
  logic          ovr_q, ovr_d;

  // Hardware load wins over the CPU write; the write is dropped entirely.
  assign upd_o = load_i | wr_i;
  assign nxt_o = load_i ? ldata_i : wdata_i;

  always_comb begin
    pend_d = pend_q;
    ovr_d  = ovr_q;
    if (load_i) begin
      pend_d = 1'b1;
      ovr_d  = ovr_q | pend_q;
    end else if (wr_i) begin
      pend_d = 1'b0;
      ovr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q    <= '0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (upd_o) q_q <= nxt_o;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  assign q_o    = q_q;
  assign pend_o = pend_q;
  assign ovr_o  = ovr_q;
endmodule

module regfile_io #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_IO     = 4,
  parameter int IO_BASE    = 20,
  parameter int BYPASS     = 1
) (
  input  logic                             clock,
  input  logic                             ctrl_reset,
  input  logic                             ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0]            ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0]            data_writeReg,
  input  logic [ADDR_WIDTH-1:0]            ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0]            ctrl_readRegB,
  output logic [DATA_WIDTH-1:0]            data_readRegA,
  output logic [DATA_WIDTH-1:0]            data_readRegB,
  input  logic [NUM_IO-1:0]                io_load,
  input  logic [NUM_IO*DATA_WIDTH-1:0]     io_data,
  output logic [NUM_IO-1:0]                io_pending,
  output logic [NUM_IO-1:0]                io_overrun,
  output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_taps
);
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;  // stored values
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] nxt;   // value loaded at next edge
  logic [NUM_REGS-1:0]                 upd;   // register changes at next edge

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i == 0) begin : g_zero
      assign regs[i] = '0;
      assign nxt[i]  = '0;
      assign upd[i]  = 1'b0;
    end else if (i >= IO_BASE && i < IO_BASE + NUM_IO) begin : g_io
      localparam int K = i - IO_BASE;
      logic wr_hit;
      assign wr_hit = ctrl_writeEnable && (ctrl_writeReg == ADDR_WIDTH'(i));
      regfile_io_ioreg #(.DW(DATA_WIDTH)) u_io (
        .clk_i  (clock),
        .rst_ni (ctrl_reset),
        .load_i (io_load[K]),
        .ldata_i(io_data[K*DATA_WIDTH +: DATA_WIDTH]),
        .wr_i   (wr_hit),
        .wdata_i(data_writeReg),
        .q_o    (regs[i]),
        .nxt_o  (nxt[i]),
        .upd_o  (upd[i]),
        .pend_o (io_pending[K]),
        .ovr_o  (io_overrun[K])
      );
    end else begin : g_gp
      logic [DATA_WIDTH-1:0] r_q;
      assign upd[i] = ctrl_writeEnable && (ctrl_writeReg == ADDR_WIDTH'(i));
      assign nxt[i] = data_writeReg;
      always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset)  r_q <= '0;
        else if (upd[i])  r_q <= nxt[i];
      end
      assign regs[i] = r_q;
    end
  end

  assign reg_taps = regs;

  // Address decode loop: out-of-range addresses and register 0 match nothing
  // and fall through to the zero default.
  always_comb begin
    data_readRegA = '0;
    data_readRegB = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (ctrl_readRegA == ADDR_WIDTH'(i))
        data_readRegA = (BYPASS != 0 && upd[i]) ? nxt[i] : regs[i];
      if (ctrl_readRegB == ADDR_WIDTH'(i))
        data_readRegB = (BYPASS != 0 && upd[i]) ? nxt[i] : regs[i];
    end
  end
endmodule
